// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Shared 640x480@60 raster timing constants, the coordinate type
//             and a small range-decode helper used by the sync generator.
//  Contents : H_*/V_* default timing, H_TOTAL/V_TOTAL, TOP_MARGIN (status
//             header height used by the pixel path), coord_t, in_window().
//  Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    localparam int H_DISPLAY  = 640;
    localparam int H_FRONT    = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BACK     = 48;
    localparam int H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY  = 480;
    localparam int V_FRONT    = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BACK     = 33;
    localparam int V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Height of the score/status header drawn at the top of the screen.
    localparam int TOP_MARGIN = 25;

    typedef logic [9:0] coord_t;

    // Half-open window test: start <= v < stop.
    function automatic logic in_window(coord_t v, coord_t start, coord_t stop);
        return (v >= start) && (v < stop);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_tick_div
//  Purpose  : Divides the system clock down to a one-clk pixel strobe.
//             The count runs 0..CLK_DIV-1 and wraps; p_tick is registered
//             and goes high in the clk after the count reaches CLK_DIV-1.
//  Ports    : clk    in  system clock
//             rst_n  in  synchronous reset, active-low
//             p_tick out one-clk pulse per pixel period
//  Params   : CLK_DIV  system clocks per pixel, legal 1..16
//  Revision : 1.0  initial release
// ============================================================================
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    // CLK_DIV=1 still needs a 1-bit counter; it simply stays at zero.
    localparam int              c_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_p_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_p_tick <= 1'b0;
        end else begin
            r_p_tick <= (r_cnt == c_LAST);
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign p_tick = r_p_tick;

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Purpose  : Raster timing source. Divides clk to the pixel rate, runs the
//             horizontal/vertical counters and drives coordinates, blanking,
//             active-low syncs and a once-per-frame update strobe.
//  Ports    : clk        in   system clock
//             rst_n      in   synchronous reset, active-low
//             p_tick     out  one-clk pulse per pixel period
//             x          out  horizontal count 0..H_TOTAL-1
//             y          out  vertical count 0..V_TOTAL-1
//             video_on   out  1 inside the visible area
//             hsync      out  active-low horizontal sync
//             vsync      out  active-low vertical sync
//             frame_tick out  one-clk pulse on entry to vertical blank
//             frame_cnt  out  8-bit frame counter (VGA_FRAME_CNT_EN only)
//  Config   : `define VGA_FRAME_CNT_EN to add the frame_cnt port and counter.
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int     c_H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int     c_V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t c_H_LAST   = coord_t'(c_H_TOTAL - 1);
    localparam coord_t c_V_LAST   = coord_t'(c_V_TOTAL - 1);
    localparam coord_t c_H_DISP   = coord_t'(H_DISPLAY);
    localparam coord_t c_V_DISP   = coord_t'(V_DISPLAY);
    localparam coord_t c_HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t c_HS_STOP  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t c_VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t c_VS_STOP  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

    logic   w_p_tick;
    coord_t w_x_nxt;
    coord_t w_y_nxt;
    logic   w_video_on_nxt;
    logic   w_hsync_nxt;
    logic   w_vsync_nxt;
    logic   w_frame_nxt;

    coord_t r_x;
    coord_t r_y;
    logic   r_video_on;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame_tick;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .p_tick (w_p_tick)
    );

    // Position the raster moves to on the next pixel strobe. The status
    // outputs are decoded from this so they register on the same edge as
    // the coordinates they describe.
    always_comb begin
        w_x_nxt = r_x + 1'b1;
        w_y_nxt = r_y;
        if (r_x == c_H_LAST) begin
            w_x_nxt = '0;
            if (r_y == c_V_LAST) begin
                w_y_nxt = '0;
            end else begin
                w_y_nxt = r_y + 1'b1;
            end
        end
        w_video_on_nxt = (w_x_nxt < c_H_DISP) && (w_y_nxt < c_V_DISP);
        w_hsync_nxt    = !in_window(w_x_nxt, c_HS_START, c_HS_STOP);
        w_vsync_nxt    = !in_window(w_y_nxt, c_VS_START, c_VS_STOP);
        w_frame_nxt    = (w_x_nxt == '0) && (w_y_nxt == c_V_DISP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_video_on   <= 1'b1;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            // p_tick is a single-clk pulse, so this is high for one clk only.
            r_frame_tick <= w_p_tick && w_frame_nxt;
            if (w_p_tick) begin
                r_x        <= w_x_nxt;
                r_y        <= w_y_nxt;
                r_video_on <= w_video_on_nxt;
                r_hsync    <= w_hsync_nxt;
                r_vsync    <= w_vsync_nxt;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_p_tick && w_frame_nxt) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign p_tick     = w_p_tick;
    assign x          = r_x;
    assign y          = r_y;
    assign video_on   = r_video_on;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_gen
//  Purpose  : Self-checking bench for vga_sync_gen. Three instances share
//             clk/rst_n: full timing at CLK_DIV=4 (u_a), full timing at
//             CLK_DIV=1 (u_b) and a miniature raster at CLK_DIV=2 (u_c)
//             so whole frames fit in a short run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_sync_gen;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       frame_tick;
        logic [7:0] frame_cnt;
    } obs_t;

    typedef struct {
        int d, hd, hf, hs, hb, vd, vf, vs, vb;
    } cfg_t;

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       p_tick;
        logic       hsync;
        logic       video_on;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_p, b_p, c_p;
    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic       a_vo, a_hs, a_vs, a_ft;
    logic       b_vo, b_hs, b_vs, b_ft;
    logic       c_vo, c_hs, c_vs, c_ft;
    logic [7:0] a_fc, b_fc, c_fc;
    obs_t       oa, ob, oc;

    vga_sync_gen #(.CLK_DIV(4)) u_a (
        .clk(clk), .rst_n(rst_n), .p_tick(a_p), .x(a_x), .y(a_y),
        .video_on(a_vo), .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_sync_gen #(.CLK_DIV(1)) u_b (
        .clk(clk), .rst_n(rst_n), .p_tick(b_p), .x(b_x), .y(b_y),
        .video_on(b_vo), .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(6), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .p_tick(c_p), .x(c_x), .y(c_y),
        .video_on(c_vo), .hsync(c_hs), .vsync(c_vs), .frame_tick(c_ft)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(c_fc)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign a_fc = 8'd0;
    assign b_fc = 8'd0;
    assign c_fc = 8'd0;
`endif

    assign oa = {a_p, a_x, a_y, a_vo, a_hs, a_vs, a_ft, a_fc};
    assign ob = {b_p, b_x, b_y, b_vo, b_hs, b_vs, b_ft, b_fc};
    assign oc = {c_p, c_x, c_y, c_vo, c_hs, c_vs, c_ft, c_fc};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n     = 0;   // clk edges since reset was last released
    cfg_t cfg_a, cfg_b, cfg_c;
    vec_t tbl[14];

    // Reference: everything follows from the number of clk edges since reset.
    // The strobe is high after edge n when n is a positive multiple of D, and
    // the raster has advanced once per strobe seen before that edge.
    function automatic logic strobe(int nn, int d);
        return (nn >= d) && (nn % d == 0);
    endfunction

    function automatic obs_t model(int nn, cfg_t c);
        obs_t o;
        int   ht, vt, ft, k, kx, ky, first;
        ht    = c.hd + c.hf + c.hs + c.hb;
        vt    = c.vd + c.vf + c.vs + c.vb;
        ft    = ht * vt;
        k     = (nn >= 1) ? (nn - 1) / c.d : 0;
        kx    = k % ht;
        ky    = (k / ht) % vt;
        first = c.vd * ht;   // pixel index of (0, V_DISPLAY)
        o.p_tick     = strobe(nn, c.d);
        o.x          = 10'(kx);
        o.y          = 10'(ky);
        o.video_on   = (kx < c.hd) && (ky < c.vd);
        o.hsync      = !((kx >= c.hd + c.hf) && (kx < c.hd + c.hf + c.hs));
        o.vsync      = !((ky >= c.vd + c.vf) && (ky < c.vd + c.vf + c.vs));
        o.frame_tick = (nn >= 1) && strobe(nn - 1, c.d) && (k % ft == first);
`ifdef VGA_FRAME_CNT_EN
        o.frame_cnt  = (k >= first) ? 8'(((k - first) / ft + 1) % 256) : 8'd0;
`else
        o.frame_cnt  = 8'd0;
`endif
        return o;
    endfunction

    task automatic check_obs(string name, obs_t got, obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 25)
                $display("FAIL %s n=%0d got p=%b x=%0d y=%0d vo=%b hs=%b vs=%b ft=%b fc=%0d need p=%b x=%0d y=%0d vo=%b hs=%b vs=%b ft=%b fc=%0d",
                         name, n, got.p_tick, got.x, got.y, got.video_on, got.hsync, got.vsync,
                         got.frame_tick, got.frame_cnt, exp.p_tick, exp.x, exp.y, exp.video_on,
                         exp.hsync, exp.vsync, exp.frame_tick, exp.frame_cnt);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 25)
                $display("FAIL %s n=%0d got %0d need %0d", name, n, got, exp);
        end
    endtask

    // One clk: track edges since release, then compare all instances on the
    // falling edge, well away from the active edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) n = 0;
        else        n++;
        @(negedge clk);
        check_obs("model_a", oa, model(n, cfg_a));
        check_obs("model_b", ob, model(n, cfg_b));
        check_obs("model_c", oc, model(n, cfg_c));
    endtask

    task automatic run_to(int target);
        rst_n = 1'b1;
        while (n < target) tick();
    endtask

    task automatic do_reset(int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    int frames_seen;
    int pix_on;

    initial begin
        cfg_a = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        cfg_b = '{1, 640, 16, 96, 48, 480, 10, 2, 33};
        cfg_c = '{2, 6, 2, 2, 2, 4, 1, 1, 2};

        //             n     x    y  p  hs vo
        tbl[0]  = '{   0,    0,   0, 0, 1, 1};
        tbl[1]  = '{   3,    0,   0, 0, 1, 1};
        tbl[2]  = '{   4,    0,   0, 1, 1, 1};
        tbl[3]  = '{   5,    1,   0, 0, 1, 1};
        tbl[4]  = '{   8,    1,   0, 1, 1, 1};
        tbl[5]  = '{   9,    2,   0, 0, 1, 1};
        tbl[6]  = '{2560,  639,   0, 1, 1, 1};
        tbl[7]  = '{2561,  640,   0, 0, 1, 0};
        tbl[8]  = '{2624,  655,   0, 1, 1, 0};
        tbl[9]  = '{2625,  656,   0, 0, 0, 0};
        tbl[10] = '{3008,  751,   0, 1, 0, 0};
        tbl[11] = '{3009,  752,   0, 0, 1, 0};
        tbl[12] = '{3197,  799,   0, 0, 1, 0};
        tbl[13] = '{3201,    0,   1, 0, 1, 1};

        // Hold reset, then walk the CLK_DIV=4 instance through one line.
        do_reset(3);
        for (int i = 0; i < 14; i++) begin
            run_to(tbl[i].n);
            check_val("tbl_x",     int'(a_x),  int'(tbl[i].x));
            check_val("tbl_y",     int'(a_y),  int'(tbl[i].y));
            check_val("tbl_ptick", int'(a_p),  int'(tbl[i].p_tick));
            check_val("tbl_hsync", int'(a_hs), int'(tbl[i].hsync));
            check_val("tbl_von",   int'(a_vo), int'(tbl[i].video_on));
        end

        // Mid-line reset for one clk at x=300: raster restarts at (0,0).
        do_reset(1);
        run_to(1201);
        check_val("pre_rst_x", int'(a_x), 300);
        do_reset(1);
        check_val("rst_x",     int'(a_x),  0);
        check_val("rst_y",     int'(a_y),  0);
        check_val("rst_hsync", int'(a_hs), 1);
        check_val("rst_vsync", int'(a_vs), 1);
        check_val("rst_ptick", int'(a_p),  0);

        // CLK_DIV=1: a line lasts 800 clks.
        run_to(800);
        check_val("div1_x799", int'(b_x), 799);
        check_val("div1_y0",   int'(b_y), 0);
        run_to(801);
        check_val("div1_x0",   int'(b_x), 0);
        check_val("div1_y1",   int'(b_y), 1);

        // Miniature raster (12x8, CLK_DIV=2): frame strobe, vsync, wrap.
        do_reset(2);
        run_to(96);
        check_val("c_ft_before", int'(c_ft), 0);
        run_to(97);
        check_val("c_ft_on",  int'(c_ft), 1);
        check_val("c_ft_x",   int'(c_x),  0);
        check_val("c_ft_y",   int'(c_y),  4);
        run_to(98);
        check_val("c_ft_off", int'(c_ft), 0);
        run_to(120);
        check_val("c_vs_pre", int'(c_vs), 1);
        run_to(121);
        check_val("c_vs_low", int'(c_vs), 0);
        run_to(145);
        check_val("c_vs_end", int'(c_vs), 1);
        run_to(191);
        check_val("c_last_x", int'(c_x), 11);
        check_val("c_last_y", int'(c_y), 7);
        run_to(193);
        check_val("c_wrap_x", int'(c_x), 0);
        check_val("c_wrap_y", int'(c_y), 0);

        // Long free run: count strobes and visible pixels on u_c over whole
        // frames (192 clks each), enough frames for frame_cnt to wrap.
        do_reset(1);
        frames_seen = 0;
        pix_on      = 0;
        for (int i = 0; i < 192 * 260; i++) begin
            tick();
            if (c_ft) frames_seen++;
            if (i < 192 && c_p && c_vo) pix_on++;
        end
        check_val("c_frames", frames_seen, 260);
        check_val("c_pix_on", pix_on, 24);

        // Randomised reset pulses with the model tracking every clk.
        for (int i = 0; i < 8000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
